vga_ram_scroll_arbiter: RTL and testbench
=========================================

# vga_ram_scroll_arbiter

Owns port A of the 2048×32 dual-port VGA text RAM and shares it between the CPU data bus and a built-in scroll/clear engine. The CPU always has priority, except when the optional fairness guard forces an engine cycle. The engine implements two commands:
- **Scroll-up-one-row:** copy word-by-word, then fill the last row.
- **Clear-screen:** fill every word.

Port B, the scanout side, is untouched by this block.

## Interface
Parameters:
- ADDR_W, 11, RAM word-address width
- BASE_ADDR, 0, word address of text row 0
- ROW_WORDS, 20, words per text row
- ROWS, 30, text rows; ROWS*ROW_WORDS + BASE_ADDR ≤ 2^ADDR_W
- STARVE_LIMIT, 8, consecutive lost arbitration cycles before the engine is forced (fairness build only)

Ports:
- clk  in  1  single clock; drives the RAM port-A clock
- rst  in  1  asynchronous, active-high reset
- cpu_en  in  1  CPU access request
- cpu_we  in  4  CPU byte write enables, passed unchanged to the RAM
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  32  CPU write data
- cpu_rdata  out  32  equals ram_rdata; valid the cycle after a granted CPU access
- cpu_stall  out  1  CPU access not granted this cycle; CPU holds its request
- cmd_valid  in  1  command request
- cmd_op  in  1  0 = scroll, 1 = clear
- cmd_fill  in  32  fill word, latched on command accept
- cmd_ready  out  1  equals !busy
- busy  out  1  engine active
- done  out  1  one-cycle pulse when a command completes
- ram_en, ram_we[3:0], ram_addr[ADDR_W-1:0], ram_wdata[31:0]  out  combinational port-A drive
- ram_rdata  in  32  registered RAM read data, one-cycle latency

## Operation
- **States:** IDLE, RD, CAP, WR, FILL.
- **Per-command registers:**
  - i: word index, ADDR_W bits
  - fill_q
  - op_q
  - hold_q: 32 bits
- **Accept:** a command is accepted on the edge where cmd_valid && cmd_ready. On accept: i ← 0, fill_q ← cmd_fill, op_q ← cmd_op. Next state is RD for scroll (or FILL if ROWS==1), FILL for clear.
- **RD (needs grant):** issues a read (ram_en=1, ram_we=0) at BASE_ADDR+i+ROW_WORDS, then goes to CAP.
- **CAP:** never uses the port. Sets hold_q ← ram_rdata, then goes to WR.
- **WR (needs grant):** writes hold_q to BASE_ADDR+i with ram_we=4'b1111, then i ← i+1.
  - If i+1 == (ROWS-1)*ROW_WORDS, go to FILL.
  - Otherwise go to RD.
- **FILL (needs grant):** writes fill_q to BASE_ADDR+i with ram_we=4'b1111, then i ← i+1.
  - If i+1 == ROWS*ROW_WORDS: go to IDLE, busy ← 0, done ← 1.
- **Grant:** the engine is granted when it is in RD, WR or FILL and (cpu_en==0 or the fairness force is active). A state that needs the port and is not granted holds all of its registers.
- **Port mux:**
  - When the engine is granted, ram_* is driven by the engine.
  - Otherwise ram_en=cpu_en and ram_we/addr/wdata come from the cpu_* inputs.
  - When neither side wants the port, ram_en=0.
- **Read-data ownership:** an engine read followed by a CPU access cannot corrupt the copy, because hold_q is captured in CAP, before any later port use.
- **Command while busy:** cmd_valid while busy is ignored. Once a command is accepted, cmd_op and cmd_fill are don't-care.
- **Mid-command reset:** reset during a command returns the block to IDLE. Memory is left partially updated and no done pulse is issued.

## Timing
- **Reset values:** busy=0, done=0, cmd_ready=1, cpu_stall=0, state=IDLE, starve count=0. cpu_rdata follows ram_rdata.
- **Engine latency from accept edge:** busy=1 from the next cycle.
- **Clear, uncontended:** 600 FILL cycles. done is high in cycle 601, with busy=0 in the same cycle, so a new command can be accepted in cycle 601.
- **Scroll, uncontended:** 580×3 + 20 = 1760 busy cycles. done is in cycle 1761.
- **CPU contention:** each cycle the CPU wins in RD/WR/FILL adds exactly one cycle. CAP cycles are never contended.
- **CPU access timing:** a granted CPU access has the RAM's native one-cycle read latency. Writes land at the same edge as the access.

## Configuration
- **Macro:** VGA_ARB_FAIRNESS_EN.
- **Defined:**
  - A starve counter counts consecutive cycles where the engine needs the port and cpu_en=1.
  - When the count reaches STARVE_LIMIT, the next such cycle is an engine cycle: cpu_stall=1, the engine is granted, and the count is cleared.
  - The count is also cleared on any engine grant, and whenever the engine does not need the port.
- **Undefined:** cpu_stall is tied to 0 and the CPU always wins. The engine can starve indefinitely.

## Test plan
- **CPU pass-through, idle:** write 0xDEADBEEF with cpu_we=4'b1111 to address 5, then read it back. cpu_rdata=0xDEADBEEF one cycle after the read. cpu_stall=0 throughout.
- **Clear:** cmd_op=1, cmd_fill=0x20202020. done pulses in cycle 601. Words 0..599 read back as 0x20202020 and word 600 is unchanged.
- **Scroll:** preload word k with value k, then issue cmd_op=0 with fill 0. Word k=k+20 for k<580, and words 580..599 are 0. done pulses in cycle 1761.
- **Contention, fairness undefined:** hold cpu_en=1 for 100 cycles during a scroll. The engine makes no progress and done is delayed by exactly 100 cycles.
- **Fairness defined:** hold cpu_en=1 continuously during a clear. cpu_stall pulses on every 9th cycle. The clear completes after 600 engine writes, with CPU requests all held across stalls.
- **Reset mid-scroll:** assert rst at cycle 300. busy=0 and done=0 immediately. A new clear is then accepted and completes normally.

Source files
------------

// File: rtl/vga_ram_scroll_arbiter.sv
// Port-A arbiter for the VGA text RAM: CPU pass-through plus a scroll/clear engine.
// Define VGA_ARB_FAIRNESS_EN to let a starved engine force one cycle every STARVE_LIMIT+1.
module vga_ram_scroll_arbiter #(
  parameter int unsigned ADDR_W       = 11,
  parameter int unsigned BASE_ADDR    = 0,
  parameter int unsigned ROW_WORDS    = 20,
  parameter int unsigned ROWS         = 30,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_en,
  input  logic [3:0]        cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  input  logic              cmd_valid,
  input  logic              cmd_op,
  input  logic [31:0]       cmd_fill,
  output logic              cmd_ready,
  output logic              busy,
  output logic              done,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  if (ROWS < 1 || ROW_WORDS < 1 || STARVE_LIMIT < 1 ||
      BASE_ADDR + ROWS * ROW_WORDS > (1 << ADDR_W)) begin : g_bad_cfg
    $error("vga_ram_scroll_arbiter: text area does not fit the RAM");
  end

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, FILL} state_t;

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ROW_OFS  = ADDR_W'(ROW_WORDS);
  localparam logic [ADDR_W-1:0] COPY_END = ADDR_W'((ROWS - 1) * ROW_WORDS);
  localparam logic [ADDR_W-1:0] FILL_END = ADDR_W'(ROWS * ROW_WORDS);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] i, i_nxt, i_inc;
  logic [31:0]       fill_q, hold_q;
  logic              op_q;
  logic              done_nxt;
  logic              accept, need, grant, force_eng;

  assign busy      = (state != IDLE);
  assign cmd_ready = ~busy;
  assign accept    = cmd_valid & cmd_ready;
  assign need      = (state == RD) || (state == WR) || (state == FILL);
  assign grant     = need & (~cpu_en | force_eng);
  assign cpu_stall = force_eng;
  assign cpu_rdata = ram_rdata;
  assign i_inc     = i + ADDR_W'(1);

`ifdef VGA_ARB_FAIRNESS_EN
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt;

  assign force_eng = need & cpu_en & (starve_cnt == CNT_W'(STARVE_LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                starve_cnt <= '0;
    else if (grant | ~need) starve_cnt <= '0;
    else                    starve_cnt <= starve_cnt + CNT_W'(1);
  end
`else
  assign force_eng = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // An ungranted port state falls through with every register unchanged.
  always_comb begin
    state_nxt = state;
    i_nxt     = i;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: if (accept) begin
        i_nxt     = '0;
        state_nxt = (!cmd_op && ROWS > 1) ? RD : FILL;
      end
      RD:   if (grant) state_nxt = CAP;
      CAP:  state_nxt = WR;
      WR:   if (grant) begin
        i_nxt     = i_inc;
        state_nxt = (op_q || i_inc == COPY_END) ? FILL : RD;
      end
      FILL: if (grant) begin
        i_nxt = i_inc;
        if (i_inc == FILL_END) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ram_en    = cpu_en;
    ram_we    = cpu_we;
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    if (grant) begin
      ram_en    = 1'b1;
      ram_we    = '1;
      ram_addr  = BASE + i;
      ram_wdata = fill_q;
      if (state == RD) begin
        ram_we   = '0;
        ram_addr = BASE + i + ROW_OFS;
      end else if (state == WR) begin
        ram_wdata = hold_q;
      end
    end
  end

  // hold_q is taken in CAP so a CPU access right after the engine read cannot disturb it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done   <= 1'b0;
      i      <= '0;
      fill_q <= '0;
      op_q   <= 1'b0;
      hold_q <= '0;
    end else begin
      done <= done_nxt;
      i    <= i_nxt;
      if (accept) begin
        fill_q <= cmd_fill;
        op_q   <= cmd_op;
      end
      if (state == CAP) hold_q <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_vga_ram_scroll_arbiter.sv
// Bench for vga_ram_scroll_arbiter: RAM model on port A, expected memory image and
// expected completion cycles derived from the command rules.
module tb_vga_ram_scroll_arbiter;
  localparam int ADDR_W      = 11;
  localparam int ROW_WORDS   = 20;
  localparam int ROWS        = 30;
  localparam int NW          = ROWS * ROW_WORDS;
  localparam int SHADOW      = NW + 40;
  localparam int CLEAR_DONE  = NW + 1;
  localparam int SCROLL_DONE = (NW - ROW_WORDS) * 3 + ROW_WORDS + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_en;
  logic [3:0]        cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata, cpu_rdata;
  logic              cpu_stall;
  logic              cmd_valid, cmd_op;
  logic [31:0]       cmd_fill;
  logic              cmd_ready, busy, done;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata, ram_rdata;

  logic [31:0] mem     [0:(1 << ADDR_W) - 1];
  logic [31:0] exp_mem [0:SHADOW - 1];
  int checks   = 0;
  int failures = 0;

  vga_ram_scroll_arbiter #(
    .ADDR_W(ADDR_W), .BASE_ADDR(0), .ROW_WORDS(ROW_WORDS), .ROWS(ROWS), .STARVE_LIMIT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_fill(cmd_fill),
    .cmd_ready(cmd_ready), .busy(busy), .done(done),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdata <= mem[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input bit ramp);
    logic [31:0] d;
    for (int k = 0; k < SHADOW; k++) begin
      d = ramp ? 32'(k) : $urandom;
      cpu_en = 1'b1; cpu_we = 4'hF; cpu_addr = ADDR_W'(k); cpu_wdata = d;
      tick();
      exp_mem[k] = d;
    end
    cpu_en = 1'b0; cpu_we = 4'h0;
  endtask

  task automatic start_cmd(input logic op, input logic [31:0] f);
    cmd_valid = 1'b1; cmd_op = op; cmd_fill = f;
    tick();
    cmd_valid = 1'b0; cmd_op = $urandom_range(0, 1) != 0; cmd_fill = $urandom;
  endtask

  task automatic wait_done(input int start, input int limit, output int n);
    n = start;
    while (done !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
  endtask

  function automatic int count_bad(output int first);
    int bad = 0;
    first = -1;
    for (int k = 0; k < SHADOW; k++)
      if (mem[k] !== exp_mem[k]) begin
        if (first < 0) first = k;
        bad++;
      end
    return bad;
  endfunction

  function automatic void model_clear(input logic [31:0] f);
    for (int k = 0; k < NW; k++) exp_mem[k] = f;
  endfunction

  function automatic void model_scroll(input logic [31:0] f);
    for (int k = 0; k < NW; k++)
      exp_mem[k] = (k < NW - ROW_WORDS) ? exp_mem[k + ROW_WORDS] : f;
  endfunction

  task automatic test_reset();
    rst = 1'b1; cpu_en = 1'b0; cpu_we = 4'h0; cpu_addr = '0; cpu_wdata = '0;
    cmd_valid = 1'b0; cmd_op = 1'b0; cmd_fill = '0;
    #2;
    checks++;
    if ({busy, done, cmd_ready, cpu_stall, ram_en} !== 5'b00100) begin
      failures++;
      $display("FAIL reset_state: got busy=%b done=%b ready=%b stall=%b ram_en=%b expected 0 0 1 0 0",
               busy, done, cmd_ready, cpu_stall, ram_en);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_cpu_passthrough();
    int bad = 0;
    logic [ADDR_W-1:0] a;
    logic [31:0] d;
    logic [3:0] we;
    cpu_en = 1'b1; cpu_we = 4'hF; cpu_addr = 11'd5; cpu_wdata = 32'hDEADBEEF;
    #1;
    checks++;
    if ({ram_en, ram_we, ram_addr, ram_wdata, cpu_stall} !== {1'b1, 4'hF, 11'd5, 32'hDEADBEEF, 1'b0}) begin
      failures++;
      $display("FAIL pass_write_drive: got en=%b we=%h addr=%0d wdata=%h stall=%b expected 1 f 5 deadbeef 0",
               ram_en, ram_we, ram_addr, ram_wdata, cpu_stall);
    end
    tick();
    cpu_we = 4'h0;
    #1;
    checks++;
    if (cpu_stall !== 1'b0 || ram_we !== 4'h0) begin
      failures++;
      $display("FAIL pass_read_drive: got stall=%b we=%h expected 0 0", cpu_stall, ram_we);
    end
    tick();
    cpu_en = 1'b0;
    checks++;
    if (cpu_rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL pass_readback: got %h expected deadbeef", cpu_rdata);
    end
    preload(1'b0);
    for (int t = 0; t < 8; t++) begin
      a = ADDR_W'($urandom_range(0, SHADOW - 1)); d = $urandom; we = 4'($urandom_range(0, 15));
      cpu_en = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
      tick();
      for (int b = 0; b < 4; b++) if (we[b]) exp_mem[a][8*b +: 8] = d[8*b +: 8];
      cpu_we = 4'h0;
      tick();
      cpu_en = 1'b0;
      if (cpu_rdata !== exp_mem[a]) begin
        bad++;
        $display("FAIL byte_write_%0d: addr %0d got %h expected %h", t, a, cpu_rdata, exp_mem[a]);
      end
    end
    checks++;
    if (bad != 0) failures++;
  endtask

  task automatic test_clear();
    int n, bad = 0, first;
    model_clear(32'h20202020);
    start_cmd(1'b1, 32'h20202020);
    n = 1;
    for (int t = 0; t < 10; t++) begin
      cmd_valid = 1'b1; cmd_op = 1'b0; cmd_fill = $urandom;
      #1;
      if (cmd_ready !== 1'b0 || busy !== 1'b1) bad++;
      tick(); n++;
    end
    cmd_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL clear_busy_ignore: got %0d cycles with ready/busy wrong, expected 0", bad);
    end
    wait_done(n, CLEAR_DONE + 50, n);
    checks++;
    if (n != CLEAR_DONE || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL clear_done_cycle: got cycle %0d busy=%b ready=%b expected %0d 0 1",
               n, busy, cmd_ready, CLEAR_DONE);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL clear_done_pulse: got done=%b one cycle later expected 0", done);
    end
    bad = count_bad(first);
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL clear_memory: got %0d bad words (first %0d) expected 0", bad, first);
    end
    cpu_en = 1'b1; cpu_we = 4'h0; cpu_addr = ADDR_W'(NW - 1);
    tick();
    cpu_en = 1'b0;
    checks++;
    if (cpu_rdata !== 32'h20202020) begin
      failures++;
      $display("FAIL clear_readback: got %h expected 20202020", cpu_rdata);
    end
  endtask

  task automatic test_scroll();
    int n, bad, first;
    preload(1'b1);
    model_scroll(32'h0);
    start_cmd(1'b0, 32'h0);
    wait_done(1, SCROLL_DONE + 50, n);
    checks++;
    if (n != SCROLL_DONE) begin
      failures++;
      $display("FAIL scroll_done_cycle: got %0d expected %0d", n, SCROLL_DONE);
    end
    tick();
    bad = count_bad(first);
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL scroll_memory: got %0d bad words (first %0d) expected 0", bad, first);
    end
  endtask

  task automatic test_back_to_back();
    int n, bad, first;
    logic [31:0] f1, f2;
    f1 = $urandom; f2 = $urandom;
    model_clear(f1);
    model_scroll(f2);
    start_cmd(1'b1, f1);
    wait_done(1, CLEAR_DONE + 50, n);
    start_cmd(1'b0, f2);
    checks++;
    if (n != CLEAR_DONE || busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_accept: got clear cycle %0d busy=%b done=%b expected %0d 1 0",
               n, busy, done, CLEAR_DONE);
    end
    wait_done(1, SCROLL_DONE + 50, n);
    checks++;
    if (n != SCROLL_DONE) begin
      failures++;
      $display("FAIL b2b_scroll_done: got %0d expected %0d", n, SCROLL_DONE);
    end
    tick();
    bad = count_bad(first);
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL b2b_memory: got %0d bad words (first %0d) expected 0", bad, first);
    end
  endtask

`ifndef VGA_ARB_FAIRNESS_EN
  task automatic test_contention();
    int n, s, bad_rd = 0, bad_stall = 0, bad, first;
    bit prev_valid = 0;
    logic [ADDR_W-1:0] prev_a = '0, a;
    logic [31:0] f;
    preload(1'b0);
    f = $urandom;
    model_scroll(f);
    // The window must open on a cycle that needs the port (not a capture cycle).
    s = $urandom_range(5, 1600);
    if (s % 3 == 2) s++;
    start_cmd(1'b0, f);
    n = 1;
    while (done !== 1'b1 && n < SCROLL_DONE + 200) begin
      if (prev_valid && cpu_rdata !== exp_mem[prev_a]) bad_rd++;
      prev_valid = 0;
      if (n >= s && n < s + 100) begin
        a = ADDR_W'(NW + $urandom_range(0, 39));
        cpu_en = 1'b1; cpu_we = 4'h0; cpu_addr = a;
        prev_valid = 1; prev_a = a;
        #1;
        if (cpu_stall !== 1'b0 || ram_addr !== a) bad_stall++;
      end else begin
        cpu_en = 1'b0;
      end
      tick(); n++;
    end
    cpu_en = 1'b0;
    checks++;
    if (n != SCROLL_DONE + 100) begin
      failures++;
      $display("FAIL contention_done_cycle: got %0d expected %0d (window at %0d)", n, SCROLL_DONE + 100, s);
    end
    checks++;
    if (bad_rd != 0 || bad_stall != 0) begin
      failures++;
      $display("FAIL contention_cpu: got %0d bad reads %0d stall/port errors expected 0 0", bad_rd, bad_stall);
    end
    tick();
    bad = count_bad(first);
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL contention_memory: got %0d bad words (first %0d) expected 0", bad, first);
    end
  endtask
`else
  task automatic test_fairness();
    int n, bad_stall = 0, bad_rd = 0, bad, first;
    bit prev_valid = 0;
    logic [ADDR_W-1:0] prev_a = '0, a;
    logic [31:0] f;
    f = $urandom;
    model_clear(f);
    start_cmd(1'b1, f);
    n = 1;
    a = ADDR_W'(NW);
    while (done !== 1'b1 && n < NW * 9 + 200) begin
      if (prev_valid && cpu_rdata !== exp_mem[prev_a]) bad_rd++;
      cpu_en = 1'b1; cpu_we = 4'h0; cpu_addr = a;
      #1;
      if (cpu_stall !== (n % 9 == 0)) bad_stall++;
      prev_valid = !cpu_stall;
      prev_a = a;
      if (!cpu_stall) a = ADDR_W'(NW + $urandom_range(0, 39));
      tick(); n++;
    end
    cpu_en = 1'b0;
    checks++;
    if (n != NW * 9 + 1) begin
      failures++;
      $display("FAIL fairness_done_cycle: got %0d expected %0d", n, NW * 9 + 1);
    end
    checks++;
    if (bad_stall != 0 || bad_rd != 0) begin
      failures++;
      $display("FAIL fairness_stall: got %0d stall errors %0d bad reads expected 0 0", bad_stall, bad_rd);
    end
    tick();
    bad = count_bad(first);
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL fairness_memory: got %0d bad words (first %0d) expected 0", bad, first);
    end
  endtask
`endif

  task automatic test_reset_mid_scroll();
    int n, bad, first;
    logic [31:0] f;
    start_cmd(1'b0, $urandom);
    n = 1;
    while (n < 300) begin tick(); n++; end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, cmd_ready} !== 3'b001) begin
      failures++;
      $display("FAIL midreset_state: got busy=%b done=%b ready=%b expected 0 0 1", busy, done, cmd_ready);
    end
    tick();
    rst = 1'b0;
    tick();
    f = $urandom;
    model_clear(f);
    start_cmd(1'b1, f);
    wait_done(1, CLEAR_DONE + 50, n);
    checks++;
    if (n != CLEAR_DONE) begin
      failures++;
      $display("FAIL midreset_clear_done: got %0d expected %0d", n, CLEAR_DONE);
    end
    tick();
    bad = count_bad(first);
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL midreset_memory: got %0d bad words (first %0d) expected 0", bad, first);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cpu_passthrough();
    test_clear();
    test_scroll();
    test_back_to_back();
`ifndef VGA_ARB_FAIRNESS_EN
    test_contention();
`else
    test_fairness();
`endif
    test_reset_mid_scroll();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
